alu_ctrl_issue: RTL and testbench
=================================

// Module: alu_ctrl_issue
// PURPOSE
//  Front end of alu_wrapper: accepts instruction + operands, decodes to the 4-bit alu_ctrl encoding, drives the ALU, registers its result.
//  Resolves branch conditions from o_alu_result only; the wrapper's o_alu_Zero is not used.
//  Two-stage valid/ready pipeline between decode and writeback/branch logic.
// PARAMETERS
//  XLEN  32  datapath width; only 32 is supported
// PORTS
//  i_clk               in   1     clock, rising edge
//  i_rst_n             in   1     asynchronous active-low reset
//  i_valid             in   1     upstream request valid
//  o_ready             out  1     request accepted when i_valid && o_ready
//  i_inst              in   32    RV32I instruction word
//  i_rs1, i_rs2        in   32    register-file operands
//  i_imm               in   32    pre-extended immediate (I/S/B/U formatted upstream)
//  o_alu_ctrl_opsel    out  4     to alu_wrapper i_alu_ctrl_opsel
//  o_aluctrl_unsigned  out  1     to alu_wrapper i_aluctrl_unsigned
//  o_alu_op1, o_alu_op2 out 32    to alu_wrapper i_rf_op1 / i_rf_op2
//  i_alu_result        in   32    from alu_wrapper o_alu_result (combinational)
//  o_valid             out  1     result valid
//  i_ready             in   1     downstream ready
//  o_result            out  32    registered ALU result
//  o_is_branch         out  1     result belongs to a conditional branch
//  o_branch_taken      out  1     branch condition true (0 unless o_is_branch)
//  o_illegal           out  1     unsupported opcode/funct3
// BEHAVIOUR
//  Stage S1 (decode reg): captures opsel, unsigned, op1, op2, branch funct3, illegal on accept.
//  Stage S2 (result reg): captures i_alu_result + branch eval when S1 valid and (!o_valid || i_ready).
//  Latency: accept at edge N -> o_valid high after edge N+1. Throughput 1/cycle with i_ready=1.
//  o_ready = !s1_valid || s1_advance (combinational); S2 holds all outputs stable while o_valid && !i_ready.
//  Decode (ALU ops driven from S1 regs; opsel codes):
//   ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLL 0101, SRL 0110, SRA 0111, SLT 1000, SLTU 1001.
//   0110011 R: funct3 + inst[30] (SUB/SRA); op1=rs1, op2=rs2.
//   0010011 I: same table; inst[30] used only for funct3=101; op2=imm.
//   0110111 LUI: ADD, op1=0, op2=imm. (Code 1010 is never driven.)
//   0000011 / 0100011 load/store: ADD rs1+imm.
//   1100011 branch: BEQ/BNE -> SUB, taken on result==0 / !=0; BLT/BGE -> SLT, taken on result[0] / !result[0];
//    BLTU/BGEU -> SLTU, same taken rule. funct3 010/011 are illegal.
//  o_aluctrl_unsigned=1 only for SLTU, SLTIU, BLTU, BGEU.
//  Illegal: ADD with op1=op2=0, o_illegal=1, o_result=0, o_is_branch=0; flows through the pipe like a normal entry.
//  Simultaneous accept + S1 advance in the same cycle is allowed; no bubble is inserted.
//  Reset (async, any time): s1_valid=0, o_valid=0, o_result=0, o_is_branch=0, o_branch_taken=0, o_illegal=0,
//   o_alu_ctrl_opsel=0, o_aluctrl_unsigned=0, o_alu_op1/op2=0. In-flight entries are dropped.
//   o_ready=1 while reset is asserted.
// CONFIGURATION
//  ALU_ISSUE_FLUSH_EN defined: adds input i_flush (1 bit). When i_flush=1 at a clock edge, both valids
//   clear and no accept occurs that cycle (o_ready forced 0 while i_flush=1). Data regs may keep stale values.
//  Undefined: port absent; the pipe empties only by reset or normal drain.
// TESTING
//  add x1,x2,x3 (0x003100B3), rs1=5, rs2=7, i_ready=1 -> opsel 0000; o_valid 2 edges later; o_result=12; is_branch=0.
//  sub (0x403100B3), rs1=3, rs2=5 -> opsel 0001; o_result=0xFFFFFFFE.
//  bltu (0x00316063), rs1=1, rs2=0xFFFFFFFF -> unsigned=1, taken=1; blt (0x00314063) same operands -> taken=0.
//  3 back-to-back adds with i_ready=0 for 5 cycles -> 2 entries held, o_ready=0, then 3 results in order; none lost or duplicated.
//  i_inst=0x0000007F -> o_illegal=1, o_result=0; next legal instruction decodes normally.
//  i_rst_n low with both stages valid -> o_valid=0 immediately (before the next edge); first accept after release behaves normally.

Source files
------------

// File: rtl/alu_ctrl_issue.sv
// ---------------------------------------------------------------------------
// alu_ctrl_issue
//
// Front end of alu_wrapper. Accepts an RV32I instruction with its operands,
// decodes it to the 4-bit ALU control code and drives the external
// combinational ALU from a decode register (S1). The ALU result is then
// captured in a result register (S2), along with the branch resolution.
// Branch conditions are derived from the ALU result alone; the wrapper's
// zero flag is not used.
//
// Pipeline: S1 (decode reg) -> external ALU -> S2 (result reg).
// Handshake is valid/ready on both sides. With i_ready held high the block
// sustains one instruction per cycle. An accept at edge N shows up on
// o_valid after edge N+1.
//
// Optional feature (macro ALU_ISSUE_FLUSH_EN):
//   defined   : adds input i_flush. A high i_flush at a clock edge clears
//               both valids and blocks the accept in that cycle.
//   undefined : no i_flush port. The pipe empties only through reset or
//               normal drain.
//
// Ports
//   i_clk, i_rst_n          clock (rising edge), async active-low reset
//   i_flush                 pipeline flush (only with ALU_ISSUE_FLUSH_EN)
//   i_valid / o_ready       upstream request handshake
//   i_inst                  RV32I instruction word
//   i_rs1, i_rs2, i_imm     operands and pre-extended immediate
//   o_alu_ctrl_opsel        ALU operation select (to alu_wrapper)
//   o_aluctrl_unsigned      unsigned compare flag (to alu_wrapper)
//   o_alu_op1, o_alu_op2    ALU operands (to alu_wrapper)
//   i_alu_result            combinational ALU result (from alu_wrapper)
//   o_valid / i_ready       downstream result handshake
//   o_result                registered ALU result
//   o_is_branch             result belongs to a conditional branch
//   o_branch_taken          branch condition true
//   o_illegal               unsupported opcode / funct3
// ---------------------------------------------------------------------------
module alu_ctrl_issue #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
`ifdef ALU_ISSUE_FLUSH_EN
    input  logic            i_flush,
`endif
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [31:0]     i_inst,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    input  logic [XLEN-1:0] i_imm,
    output logic [3:0]      o_alu_ctrl_opsel,
    output logic            o_aluctrl_unsigned,
    output logic [XLEN-1:0] o_alu_op1,
    output logic [XLEN-1:0] o_alu_op2,
    input  logic [XLEN-1:0] i_alu_result,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_result,
    output logic            o_is_branch,
    output logic            o_branch_taken,
    output logic            o_illegal
);

    // ALU operation select codes
    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLL  = 4'b0101;
    localparam logic [3:0] OP_SRL  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b1000;
    localparam logic [3:0] OP_SLTU = 4'b1001;

    // RV32I major opcodes handled here
    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // funct3 -> opsel for the shared R/I arithmetic table. 'alt' selects
    // SUB/SRA; the caller decides when inst[30] is allowed to matter.
    function automatic logic [3:0] arith_sel(input logic [2:0] f3, input logic alt);
        logic [3:0] sel;
        case (f3)
            3'b000:  sel = alt ? OP_SUB : OP_ADD;
            3'b001:  sel = OP_SLL;
            3'b010:  sel = OP_SLT;
            3'b011:  sel = OP_SLTU;
            3'b100:  sel = OP_XOR;
            3'b101:  sel = alt ? OP_SRA : OP_SRL;
            3'b110:  sel = OP_OR;
            default: sel = OP_AND;
        endcase
        return sel;
    endfunction

    // Branch resolution from the ALU result only. BEQ/BNE run SUB and look
    // at zero; the compare branches run SLT/SLTU and look at bit 0. funct3[0]
    // inverts the sense in both families (BNE, BGE, BGEU).
    function automatic logic br_taken(input logic [2:0] f3, input logic [XLEN-1:0] res);
        logic cond;
        if (f3[2] == 1'b0) begin
            cond = (res == '0);
        end else begin
            cond = res[0];
        end
        return cond ^ f3[0];
    endfunction

    // ------------------------------------------------------------------
    // Instruction field extraction and decode (combinational)
    // ------------------------------------------------------------------
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            alt_bit;
    logic            unused_inst;

    assign opcode  = i_inst[6:0];
    assign funct3  = i_inst[14:12];
    assign alt_bit = i_inst[30];
    // Register indices and remaining funct7 bits are resolved upstream.
    assign unused_inst = ^{i_inst[31], i_inst[29:15], i_inst[11:7]};

    logic [3:0]      dec_opsel;
    logic            dec_uns;
    logic [XLEN-1:0] dec_op1;
    logic [XLEN-1:0] dec_op2;
    logic            dec_br;
    logic            dec_ill;

    always_comb begin
        dec_opsel = OP_ADD;
        dec_uns   = 1'b0;
        dec_op1   = i_rs1;
        dec_op2   = i_rs2;
        dec_br    = 1'b0;
        dec_ill   = 1'b0;

        case (opcode)
            OPC_R: begin
                dec_opsel = arith_sel(funct3, alt_bit);
                dec_uns   = (funct3 == 3'b011);
            end
            OPC_I: begin
                // inst[30] is part of the immediate except for SRLI/SRAI
                dec_opsel = arith_sel(funct3, alt_bit && (funct3 == 3'b101));
                dec_uns   = (funct3 == 3'b011);
                dec_op2   = i_imm;
            end
            OPC_LUI: begin
                dec_op1 = '0;
                dec_op2 = i_imm;
            end
            OPC_LOAD, OPC_STORE: begin
                dec_op2 = i_imm;
            end
            OPC_BRANCH: begin
                dec_br = 1'b1;
                case (funct3)
                    3'b000, 3'b001: dec_opsel = OP_SUB;
                    3'b100, 3'b101: dec_opsel = OP_SLT;
                    3'b110, 3'b111: begin
                        dec_opsel = OP_SLTU;
                        dec_uns   = 1'b1;
                    end
                    default: dec_ill = 1'b1;
                endcase
            end
            default: dec_ill = 1'b1;
        endcase

        // Illegal entries travel as a harmless 0 + 0 so the ALU output is 0.
        if (dec_ill) begin
            dec_opsel = OP_ADD;
            dec_uns   = 1'b0;
            dec_op1   = '0;
            dec_op2   = '0;
            dec_br    = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic            flush;
    logic            s1_valid_q, s1_valid_d;
    logic            s2_valid_q, s2_valid_d;
    logic            s2_free;
    logic            s1_advance;
    logic            accept;

`ifdef ALU_ISSUE_FLUSH_EN
    assign flush = i_flush;
`else
    assign flush = 1'b0;
`endif

    assign s2_free    = !s2_valid_q || i_ready;
    assign s1_advance = s1_valid_q && s2_free && !flush;
    // Reset term keeps o_ready high while i_rst_n is low, whatever i_flush does.
    assign o_ready    = !i_rst_n || (!flush && (!s1_valid_q || s1_advance));
    assign accept     = i_valid && o_ready;

    // ------------------------------------------------------------------
    // S1: decode register, drives the external ALU
    // ------------------------------------------------------------------
    logic [3:0]      s1_opsel_q, s1_opsel_d;
    logic            s1_uns_q,   s1_uns_d;
    logic [XLEN-1:0] s1_op1_q,   s1_op1_d;
    logic [XLEN-1:0] s1_op2_q,   s1_op2_d;
    logic            s1_br_q,    s1_br_d;
    logic [2:0]      s1_f3_q,    s1_f3_d;
    logic            s1_ill_q,   s1_ill_d;

    // ------------------------------------------------------------------
    // S2: result register, drives the downstream outputs
    // ------------------------------------------------------------------
    logic [XLEN-1:0] s2_result_q, s2_result_d;
    logic            s2_br_q,     s2_br_d;
    logic            s2_taken_q,  s2_taken_d;
    logic            s2_ill_q,    s2_ill_d;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_opsel_d = s1_opsel_q;
        s1_uns_d   = s1_uns_q;
        s1_op1_d   = s1_op1_q;
        s1_op2_d   = s1_op2_q;
        s1_br_d    = s1_br_q;
        s1_f3_d    = s1_f3_q;
        s1_ill_d   = s1_ill_q;

        // S1 data only reloads on accept, so the ALU inputs stay steady
        // while an entry waits for S2 to free up.
        if (flush) begin
            s1_valid_d = 1'b0;
        end else if (accept) begin
            s1_valid_d = 1'b1;
            s1_opsel_d = dec_opsel;
            s1_uns_d   = dec_uns;
            s1_op1_d   = dec_op1;
            s1_op2_d   = dec_op2;
            s1_br_d    = dec_br;
            s1_f3_d    = funct3;
            s1_ill_d   = dec_ill;
        end else if (s1_advance) begin
            s1_valid_d = 1'b0;
        end
    end

    always_comb begin
        s2_valid_d  = s2_valid_q;
        s2_result_d = s2_result_q;
        s2_br_d     = s2_br_q;
        s2_taken_d  = s2_taken_q;
        s2_ill_d    = s2_ill_q;

        if (flush) begin
            s2_valid_d = 1'b0;
        end else if (s1_advance) begin
            s2_valid_d  = 1'b1;
            s2_result_d = s1_ill_q ? '0 : i_alu_result;
            s2_br_d     = s1_br_q;
            s2_taken_d  = s1_br_q && br_taken(s1_f3_q, i_alu_result);
            s2_ill_d    = s1_ill_q;
        end else if (i_ready) begin
            s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_opsel_q  <= OP_ADD;
            s1_uns_q    <= 1'b0;
            s1_op1_q    <= '0;
            s1_op2_q    <= '0;
            s1_br_q     <= 1'b0;
            s1_f3_q     <= 3'b000;
            s1_ill_q    <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_result_q <= '0;
            s2_br_q     <= 1'b0;
            s2_taken_q  <= 1'b0;
            s2_ill_q    <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_opsel_q  <= s1_opsel_d;
            s1_uns_q    <= s1_uns_d;
            s1_op1_q    <= s1_op1_d;
            s1_op2_q    <= s1_op2_d;
            s1_br_q     <= s1_br_d;
            s1_f3_q     <= s1_f3_d;
            s1_ill_q    <= s1_ill_d;
            s2_valid_q  <= s2_valid_d;
            s2_result_q <= s2_result_d;
            s2_br_q     <= s2_br_d;
            s2_taken_q  <= s2_taken_d;
            s2_ill_q    <= s2_ill_d;
        end
    end

    assign o_alu_ctrl_opsel   = s1_opsel_q;
    assign o_aluctrl_unsigned = s1_uns_q;
    assign o_alu_op1          = s1_op1_q;
    assign o_alu_op2          = s1_op2_q;

    assign o_valid        = s2_valid_q;
    assign o_result       = s2_result_q;
    assign o_is_branch    = s2_br_q;
    assign o_branch_taken = s2_taken_q;
    assign o_illegal      = s2_ill_q;

endmodule

// File: tb/tb_alu_ctrl_issue.sv
// ---------------------------------------------------------------------------
// tb_alu_ctrl_issue
//
// Bench for alu_ctrl_issue. A small stand-in for alu_wrapper closes the loop
// from the ALU control outputs back to i_alu_result. A reference model turns
// each accepted instruction straight into its architectural result (sum,
// difference, compare, branch outcome) and queues it. The compare process
// checks every presented result in order. Directed sequences pin latency,
// backpressure, illegal handling and reset against hand-computed values.
// ---------------------------------------------------------------------------
module tb_alu_ctrl_issue;

    logic        clk;
    logic        rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_inst, i_rs1, i_rs2, i_imm;
    logic [3:0]  o_alu_ctrl_opsel;
    logic        o_aluctrl_unsigned;
    logic [31:0] o_alu_op1, o_alu_op2;
    logic [31:0] i_alu_result;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_result;
    logic        o_is_branch, o_branch_taken, o_illegal;
`ifdef ALU_ISSUE_FLUSH_EN
    logic        i_flush;
    initial i_flush = 1'b0;
`endif

    alu_ctrl_issue #(.XLEN(32)) dut (
        .i_clk              (clk),
        .i_rst_n            (rst_n),
`ifdef ALU_ISSUE_FLUSH_EN
        .i_flush            (i_flush),
`endif
        .i_valid            (i_valid),
        .o_ready            (o_ready),
        .i_inst             (i_inst),
        .i_rs1              (i_rs1),
        .i_rs2              (i_rs2),
        .i_imm              (i_imm),
        .o_alu_ctrl_opsel   (o_alu_ctrl_opsel),
        .o_aluctrl_unsigned (o_aluctrl_unsigned),
        .o_alu_op1          (o_alu_op1),
        .o_alu_op2          (o_alu_op2),
        .i_alu_result       (i_alu_result),
        .o_valid            (o_valid),
        .i_ready            (i_ready),
        .o_result           (o_result),
        .o_is_branch        (o_is_branch),
        .o_branch_taken     (o_branch_taken),
        .o_illegal          (o_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the combinational alu_wrapper datapath
    always_comb begin
        case (o_alu_ctrl_opsel)
            4'd0:    i_alu_result = o_alu_op1 + o_alu_op2;
            4'd1:    i_alu_result = o_alu_op1 - o_alu_op2;
            4'd2:    i_alu_result = o_alu_op1 & o_alu_op2;
            4'd3:    i_alu_result = o_alu_op1 | o_alu_op2;
            4'd4:    i_alu_result = o_alu_op1 ^ o_alu_op2;
            4'd5:    i_alu_result = o_alu_op1 << o_alu_op2[4:0];
            4'd6:    i_alu_result = o_alu_op1 >> o_alu_op2[4:0];
            4'd7:    i_alu_result = $signed(o_alu_op1) >>> o_alu_op2[4:0];
            4'd8:    i_alu_result = {31'd0, $signed(o_alu_op1) < $signed(o_alu_op2)};
            4'd9:    i_alu_result = {31'd0, o_alu_op1 < o_alu_op2};
            default: i_alu_result = 32'hDEAD_BEEF;
        endcase
    end

    typedef struct packed {
        logic [31:0] res;
        logic        br;
        logic        tk;
        logic        ill;
    } exp_t;

    // Architectural meaning of one instruction
    function automatic exp_t model(input logic [31:0] inst, input logic [31:0] a,
                                   input logic [31:0] rb, input logic [31:0] imm);
        exp_t        e;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [31:0] b;
        logic        lts, ltu;
        op  = inst[6:0];
        f3  = inst[14:12];
        e   = '0;
        lts = $signed(a) < $signed(rb);
        ltu = a < rb;
        case (op)
            7'h33, 7'h13: begin
                b = (op == 7'h33) ? rb : imm;
                case (f3)
                    3'd0: e.res = (op == 7'h33 && inst[30]) ? a - b : a + b;
                    3'd1: e.res = a << b[4:0];
                    3'd2: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    3'd3: e.res = (a < b) ? 32'd1 : 32'd0;
                    3'd4: e.res = a ^ b;
                    3'd5: begin
                        if (inst[30]) e.res = $signed(a) >>> b[4:0];
                        else          e.res = a >> b[4:0];
                    end
                    3'd6: e.res = a | b;
                    default: e.res = a & b;
                endcase
            end
            7'h37: e.res = imm;
            7'h03, 7'h23: e.res = a + imm;
            7'h63: begin
                e.br = 1'b1;
                case (f3)
                    3'd0: begin e.res = a - rb; e.tk = (a == rb); end
                    3'd1: begin e.res = a - rb; e.tk = (a != rb); end
                    3'd4: begin e.res = {31'd0, lts}; e.tk = lts;  end
                    3'd5: begin e.res = {31'd0, lts}; e.tk = !lts; end
                    3'd6: begin e.res = {31'd0, ltu}; e.tk = ltu;  end
                    3'd7: begin e.res = {31'd0, ltu}; e.tk = !ltu; end
                    default: begin e.br = 1'b0; e.ill = 1'b1; end
                endcase
            end
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction

    function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3,
                                       input logic [6:0] op);
        return {f7, 5'd3, 5'd2, f3, 5'd1, op};
    endfunction

    int n_cmp  = 0;
    int n_fail = 0;
    int n_in   = 0;
    int n_out  = 0;
    int n_drop = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Scoreboard / compare process, evaluated mid-cycle
    // ------------------------------------------------------------------
    exp_t sbq[$];

    always @(negedge clk) begin
        if (!rst_n) begin
            n_drop += sbq.size();
            sbq.delete();
        end else begin
            // Only two slots exist: with both full and no drain, no accept.
            chk("sb_ready", o_ready, !(sbq.size() >= 2 && !i_ready));
            if (o_valid) begin
                if (sbq.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL sb_spurious_valid: got o_valid=1, expected no pending entry (t=%0t)", $time);
                end else begin
                    chk("sb_result",  o_result,       sbq[0].res);
                    chk("sb_branch",  o_is_branch,    sbq[0].br);
                    chk("sb_taken",   o_branch_taken, sbq[0].tk);
                    chk("sb_illegal", o_illegal,      sbq[0].ill);
                end
            end
            if (o_valid && i_ready && sbq.size() > 0) begin
                void'(sbq.pop_front());
                n_out++;
            end
            if (i_valid && o_ready) begin
                sbq.push_back(model(i_inst, i_rs1, i_rs2, i_imm));
                n_in++;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (called at posedge + 1)
    // ------------------------------------------------------------------
    task automatic drive(input logic [31:0] inst, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] imm);
        i_valid = 1'b1;
        i_inst  = inst;
        i_rs1   = a;
        i_rs2   = b;
        i_imm   = imm;
    endtask

    task automatic wait_accept(input string nm);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            ok = o_ready;
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_accept_timeout: got o_ready=0 for 50 cycles, expected accept", nm);
        end
    endtask

    task automatic issue(input string nm, input logic [31:0] inst, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] imm);
        drive(inst, a, b, imm);
        wait_accept(nm);
        i_valid = 1'b0;
    endtask

    logic [31:0] tv_inst[$], tv_a[$], tv_b[$], tv_imm[$];

    task automatic tv(input logic [31:0] inst, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] imm);
        tv_inst.push_back(inst);
        tv_a.push_back(a);
        tv_b.push_back(b);
        tv_imm.push_back(imm);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    exp_t pin;

    initial begin
        rst_n   = 1'b0;
        i_valid = 1'b0;
        i_inst  = 32'd0;
        i_rs1   = 32'd0;
        i_rs2   = 32'd0;
        i_imm   = 32'd0;
        i_ready = 1'b1;

        // Model pins against hand-computed values
        pin = model(32'h003100B3, 32'd5, 32'd7, 32'd0);
        chk("model_add", pin.res, 32'd12);
        pin = model(32'h403100B3, 32'd3, 32'd5, 32'd0);
        chk("model_sub", pin.res, 32'hFFFF_FFFE);
        pin = model(32'h00316063, 32'd1, 32'hFFFF_FFFF, 32'd0);
        chk("model_bltu_taken", pin.tk, 1'b1);
        pin = model(32'h0000007F, 32'd9, 32'd9, 32'd9);
        chk("model_illegal", {pin.ill, pin.res[0]}, 2'b10);

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready",    o_ready, 1'b1);
        chk("rst_valid",    o_valid, 1'b0);
        chk("rst_result",   o_result, 32'd0);
        chk("rst_opsel",    o_alu_ctrl_opsel, 4'd0);
        chk("rst_unsigned", o_aluctrl_unsigned, 1'b0);
        chk("rst_op1",      o_alu_op1, 32'd0);
        chk("rst_op2",      o_alu_op2, 32'd0);
        chk("rst_flags",    {o_is_branch, o_branch_taken, o_illegal}, 3'b000);
        rst_n = 1'b1;

        // add x1,x2,x3 : latency and decode
        issue("add", 32'h003100B3, 32'd5, 32'd7, 32'd0);
        chk("add_opsel", o_alu_ctrl_opsel, 4'b0000);
        chk("add_op1",   o_alu_op1, 32'd5);
        chk("add_op2",   o_alu_op2, 32'd7);
        chk("add_valid_early", o_valid, 1'b0);
        @(posedge clk); #1;
        chk("add_valid",  o_valid, 1'b1);
        chk("add_result", o_result, 32'd12);
        chk("add_branch", o_is_branch, 1'b0);

        // sub
        issue("sub", 32'h403100B3, 32'd3, 32'd5, 32'd0);
        chk("sub_opsel", o_alu_ctrl_opsel, 4'b0001);
        @(posedge clk); #1;
        chk("sub_result", o_result, 32'hFFFF_FFFE);

        // bltu / blt with the same operands
        issue("bltu", 32'h00316063, 32'd1, 32'hFFFF_FFFF, 32'd0);
        chk("bltu_unsigned", o_aluctrl_unsigned, 1'b1);
        chk("bltu_opsel", o_alu_ctrl_opsel, 4'b1001);
        @(posedge clk); #1;
        chk("bltu_branch", o_is_branch, 1'b1);
        chk("bltu_taken",  o_branch_taken, 1'b1);
        issue("blt", 32'h00314063, 32'd1, 32'hFFFF_FFFF, 32'd0);
        chk("blt_unsigned", o_aluctrl_unsigned, 1'b0);
        chk("blt_opsel", o_alu_ctrl_opsel, 4'b1000);
        @(posedge clk); #1;
        chk("blt_branch", o_is_branch, 1'b1);
        chk("blt_taken",  o_branch_taken, 1'b0);

        // Illegal opcode, then a legal addi x1,x0,10
        issue("illegal", 32'h0000007F, 32'h1234, 32'h5678, 32'h9ABC);
        @(posedge clk); #1;
        chk("ill_flag",   o_illegal, 1'b1);
        chk("ill_result", o_result, 32'd0);
        chk("ill_branch", o_is_branch, 1'b0);
        issue("addi", 32'h00A00093, 32'd3, 32'd0, 32'd10);
        @(posedge clk); #1;
        chk("addi_illegal", o_illegal, 1'b0);
        chk("addi_result",  o_result, 32'd13);

        // Back-to-back table through the scoreboard
        tv(mk(7'h00, 3'd7, 7'h33), 32'hF0F0_1234, 32'h0FF0_FF00, 32'd0);  // and
        tv(mk(7'h00, 3'd6, 7'h33), 32'hF0F0_1234, 32'h0FF0_FF00, 32'd0);  // or
        tv(mk(7'h00, 3'd4, 7'h33), 32'hF0F0_1234, 32'h0FF0_FF00, 32'd0);  // xor
        tv(mk(7'h00, 3'd1, 7'h33), 32'h8000_0011, 32'd4, 32'd0);          // sll
        tv(mk(7'h00, 3'd5, 7'h33), 32'h8000_0010, 32'd4, 32'd0);          // srl
        tv(mk(7'h20, 3'd5, 7'h33), 32'h8000_0010, 32'd4, 32'd0);          // sra
        tv(mk(7'h00, 3'd2, 7'h33), 32'hFFFF_FFFF, 32'd1, 32'd0);          // slt
        tv(mk(7'h00, 3'd3, 7'h33), 32'hFFFF_FFFF, 32'd1, 32'd0);          // sltu
        tv(mk(7'h7F, 3'd3, 7'h13), 32'd5, 32'd0, 32'hFFFF_FFFF);          // sltiu
        tv(mk(7'h20, 3'd5, 7'h13), 32'h8000_0000, 32'd0, 32'h0000_0404);  // srai
        tv(mk(7'h00, 3'd5, 7'h13), 32'h8000_0000, 32'd0, 32'h0000_0004);  // srli
        tv(mk(7'h20, 3'd0, 7'h13), 32'd10, 32'd0, 32'hFFFF_FC03);         // addi, bit30 set
        tv(mk(7'h55, 3'd2, 7'h37), 32'h1234, 32'd0, 32'hABCD_E000);       // lui
        tv(mk(7'h00, 3'd2, 7'h03), 32'h100, 32'd0, 32'hFFFF_FFFC);        // lw
        tv(mk(7'h00, 3'd2, 7'h23), 32'h200, 32'd0, 32'd8);                // sw
        tv(mk(7'h00, 3'd0, 7'h63), 32'd7, 32'd7, 32'd0);                  // beq
        tv(mk(7'h00, 3'd1, 7'h63), 32'd7, 32'd7, 32'd0);                  // bne
        tv(mk(7'h00, 3'd5, 7'h63), 32'hFFFF_FFFF, 32'd1, 32'd0);          // bge
        tv(mk(7'h00, 3'd7, 7'h63), 32'hFFFF_FFFF, 32'd1, 32'd0);          // bgeu
        tv(mk(7'h00, 3'd2, 7'h63), 32'd1, 32'd2, 32'd0);                  // branch f3=010
        tv(mk(7'h00, 3'd0, 7'h73), 32'd1, 32'd2, 32'd3);                  // unknown opcode
        for (int i = 0; i < tv_inst.size(); i++) begin
            drive(tv_inst[i], tv_a[i], tv_b[i], tv_imm[i]);
            wait_accept("table");
        end
        i_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // Backpressure: two entries held, third waits
        i_ready = 1'b0;
        issue("bp0", 32'h003100B3, 32'd10, 32'd1, 32'd0);
        drive(32'h003100B3, 32'd20, 32'd1, 32'd0);
        wait_accept("bp1");
        drive(32'h003100B3, 32'd30, 32'd1, 32'd0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_ready_low", o_ready, 1'b0);
            chk("bp_valid",     o_valid, 1'b1);
            chk("bp_hold",      o_result, 32'd11);
            @(posedge clk);
            #1;
        end
        i_ready = 1'b1;
        wait_accept("bp2");
        i_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // Reset with both stages occupied
        i_ready = 1'b0;
        issue("rs0", 32'h003100B3, 32'd100, 32'd1, 32'd0);
        issue("rs1", 32'h003100B3, 32'd200, 32'd1, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid",  o_valid, 1'b0);
        chk("arst_ready",  o_ready, 1'b1);
        chk("arst_result", o_result, 32'd0);
        chk("arst_opsel",  o_alu_ctrl_opsel, 4'd0);
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        i_ready = 1'b1;
        issue("post_rst", 32'h003100B3, 32'd5, 32'd7, 32'd0);
        chk("post_rst_valid_early", o_valid, 1'b0);
        @(posedge clk); #1;
        chk("post_rst_valid",  o_valid, 1'b1);
        chk("post_rst_result", o_result, 32'd12);

        repeat (4) @(posedge clk);
        #1;
        chk("drain_count", n_out, n_in - n_drop);
        chk("drain_empty", sbq.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
